// File: rtl/seq_det_param_moore.sv
// Parametrised Moore detector for a PAT_LEN-bit serial pattern with saturating match count.
// Define SEQ_PAT_LOAD_EN to make the pattern run-time loadable through pat_load/pat_in.
module seq_det_param_moore #(
    parameter int unsigned           PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0]    PATTERN = PAT_LEN'(6'b110011),
    parameter int unsigned           CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               cnt_clr,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
    logic [PAT_LEN-1:0] pat_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               z_d;
    logic               load;
    logic               accept;
    logic               hit;

`ifdef SEQ_PAT_LOAD_EN
    logic [PAT_LEN-1:0] pat_d;

    assign load = pat_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= PATTERN;
        end else begin
            pat_q <= pat_d;
        end
    end

    always_comb begin
        pat_d = pat_q;
        if (pat_load) begin
            pat_d = pat_in;
        end
    end
`else
    logic unused_pat_ports;

    assign load             = 1'b0;
    assign pat_q            = PATTERN;
    assign unused_pat_ports = ^{pat_load, pat_in};
`endif

    // A pattern load swallows any bit offered in the same cycle.
    assign accept = x_valid & ~load;
    assign hist_n = {hist_q[PAT_LEN-2:0], x};
    assign fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    assign hit    = accept && (fill_n == FILL_FULL) && (hist_n == pat_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            z         <= z_d;
            match_cnt <= cnt_d;
        end
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = hit;
        cnt_d  = match_cnt;

        if (load) begin
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_n;
            // Non-overlapping mode restarts the window after every match.
            fill_d = (hit && !overlap) ? '0 : fill_n;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (match_cnt != '1)) begin
            cnt_d = match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_param_moore.sv
// Scoreboard bench for seq_det_param_moore; CNT_W is narrowed to 2 to reach saturation quickly.
module tb_seq_det_param_moore;

    localparam int unsigned PL   = 6;
    localparam int unsigned CW   = 2;
    localparam logic [PL-1:0] PAT_DEF = 6'b110011;
    localparam int unsigned CMAX = (1 << CW) - 1;

    typedef struct {
        logic        z;
        int unsigned cnt;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          x;
    logic          x_valid;
    logic          overlap;
    logic          cnt_clr;
    logic          pat_load;
    logic [PL-1:0] pat_in;
    logic          z;
    logic [CW-1:0] match_cnt;

    int unsigned n_cmp;
    int unsigned n_bad;
    string       cur;
    exp_t        exp_q[$];

    logic [PL-1:0] m_hist;
    int unsigned   m_fill;
    logic [PL-1:0] m_pat;
    int unsigned   m_cnt;
    logic          m_z;

    seq_det_param_moore #(
        .PAT_LEN (PL),
        .PATTERN (PAT_DEF),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .x_valid   (x_valid),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .z         (z),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = '0;
        m_fill = 0;
        m_pat  = PAT_DEF;
        m_cnt  = 0;
        m_z    = 1'b0;
    endtask

    // Reference behaviour of one clock edge, written from the stream's point of view.
    task automatic model_step(input logic bx, input logic xv, input logic ov,
                              input logic clr, input logic pl, input logic [PL-1:0] pi);
        logic hitm;
        hitm = 1'b0;
`ifdef SEQ_PAT_LOAD_EN
        if (pl) begin
            m_pat  = pi;
            m_fill = 0;
        end else
`endif
        if (xv) begin
            m_hist = {m_hist[PL-2:0], bx};
            if (m_fill < PL) m_fill++;
            hitm = (m_fill == PL) && (m_hist == m_pat);
            if (hitm && !ov) m_fill = 0;
        end
        m_z = hitm;
        if (clr) m_cnt = 0;
        else if (hitm && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic step(input logic bx, input logic xv, input logic ov,
                        input logic clr, input logic pl, input logic [PL-1:0] pi);
        exp_t e;
        @(negedge clk);
        x        = bx;
        x_valid  = xv;
        overlap  = ov;
        cnt_clr  = clr;
        pat_load = pl;
        pat_in   = pi;
        model_step(bx, xv, ov, clr, pl, pi);
        e.z   = m_z;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("%s.z", cur), int'(z), int'(e.z));
        check($sformatf("%s.cnt", cur), int'(match_cnt), e.cnt);
    endtask

    task automatic send_seq(input logic [31:0] bits, input int n, input logic ov, input int gap_max);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b1, ov, 1'b0, 1'b0, '0);
            if (gap_max > 0 && i < n - 1) begin
                int g;
                g = $urandom_range(gap_max, 1);
                for (int k = 0; k < g; k++) step(1'b0, 1'b0, ov, 1'b0, 1'b0, '0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        x_valid  = 1'b0;
        cnt_clr  = 1'b0;
        pat_load = 1'b0;
        #1;
        check($sformatf("%s.rst_z", cur), int'(z), 0);
        check($sformatf("%s.rst_cnt", cur), int'(match_cnt), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        x        = 1'b0;
        x_valid  = 1'b0;
        overlap  = 1'b1;
        cnt_clr  = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
        model_reset();

        cur = "reset";
        #12;
        check("reset.z", int'(z), 0);
        check("reset.cnt", int'(match_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        cur = "basic";
        send_seq(32'b110011, 6, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        cur = "ovl_on";
        do_reset();
        send_seq(32'b1100110011, 10, 1'b1, 0);

        cur = "ovl_off";
        do_reset();
        send_seq(32'b1100110011, 10, 1'b0, 0);

        cur = "gaps";
        do_reset();
        send_seq(32'b110011, 6, 1'b1, 3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Reset while z is high must clear z and the count without a clock edge.
        cur = "rst_hit";
        do_reset();
        send_seq(32'b110011, 6, 1'b1, 0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_hit.z_async", int'(z), 0);
        check("rst_hit.cnt_async", int'(match_cnt), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        cur = "rst_mid";
        send_seq(32'b11001, 5, 1'b1, 0);
        do_reset();
        send_seq(32'b1, 1, 1'b1, 0);

        cur = "sat";
        do_reset();
        send_seq(32'b1100110011001100110011, 22, 1'b1, 0);
        check("sat.cnt_max", int'(match_cnt), CMAX);

        cur = "clr_hit";
        send_seq(32'b001, 3, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("clr_hit.z", int'(z), 1);
        check("clr_hit.cnt", int'(match_cnt), 0);

`ifdef SEQ_PAT_LOAD_EN
        cur = "load";
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b101101);
        send_seq(32'b101101, 6, 1'b1, 0);
        check("load.new_hit", int'(match_cnt), 1);
        send_seq(32'b110011, 6, 1'b0, 0);
`endif

        cur = "rand";
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [PL-1:0] rp;
            rp = (($urandom_range(3, 0) == 0) ? PAT_DEF : PL'($urandom));
            step(1'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom),
                 ($urandom_range(31, 0) == 0), ($urandom_range(63, 0) == 0), rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
